// File: rtl/cursor_nav.sv
// Minesweeper cursor navigation: turns debounced button pulses into cursor moves
// (wrap or clamp at the grid edges) and reveal requests over a req/ack handshake.
module cursor_nav #(
  parameter int unsigned GRID_W = 8,
  parameter int unsigned GRID_H = 8,
  parameter int unsigned X_BITS = 3,
  parameter int unsigned Y_BITS = 3,
  parameter int unsigned WRAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic              down_valid,
  input  logic              left_valid,
  input  logic              right_valid,
  input  logic              center_valid,
  input  logic              enable,
  input  logic              reveal_ack,
  output logic [X_BITS-1:0] cur_x,
  output logic [Y_BITS-1:0] cur_y,
  output logic              moved,
  output logic              reveal_req,
  output logic [X_BITS-1:0] reveal_x,
  output logic [Y_BITS-1:0] reveal_y,
  output logic              busy
);

  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
  localparam bit                DO_WRAP = (WRAP != 0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [X_BITS-1:0]   cur_x_q, cur_x_d;
  logic [Y_BITS-1:0]   cur_y_q, cur_y_d;
  logic [X_BITS-1:0]   reveal_x_q, reveal_x_d;
  logic [Y_BITS-1:0]   reveal_y_q, reveal_y_d;
  logic                moved_q, moved_d;

  // Next-state: reveal latch, per-axis move with explicit edge compares
  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    reveal_x_d = reveal_x_q;
    reveal_y_d = reveal_y_q;
    moved_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (center_valid) begin
            reveal_x_d = cur_x_q;
            reveal_y_d = cur_y_q;
            state_d    = REQ;
          end else begin
            if (right_valid && !left_valid) begin
              if (cur_x_q == X_MAX) cur_x_d = DO_WRAP ? '0 : cur_x_q;
              else                  cur_x_d = cur_x_q + X_BITS'(1);
            end else if (left_valid && !right_valid) begin
              if (cur_x_q == '0)    cur_x_d = DO_WRAP ? X_MAX : cur_x_q;
              else                  cur_x_d = cur_x_q - X_BITS'(1);
            end

            if (down_valid && !up_valid) begin
              if (cur_y_q == Y_MAX) cur_y_d = DO_WRAP ? '0 : cur_y_q;
              else                  cur_y_d = cur_y_q + Y_BITS'(1);
            end else if (up_valid && !down_valid) begin
              if (cur_y_q == '0)    cur_y_d = DO_WRAP ? Y_MAX : cur_y_q;
              else                  cur_y_d = cur_y_q - Y_BITS'(1);
            end

            moved_d = (cur_x_d != cur_x_q) || (cur_y_d != cur_y_q);
          end
        end
      end
      REQ: begin
        if (reveal_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      reveal_x_q <= '0;
      reveal_y_q <= '0;
      moved_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      reveal_x_q <= reveal_x_d;
      reveal_y_q <= reveal_y_d;
      moved_q    <= moved_d;
    end
  end

  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign moved      = moved_q;
  assign reveal_x   = reveal_x_q;
  assign reveal_y   = reveal_y_q;
  assign reveal_req = (state_q == REQ);
  assign busy       = (state_q == REQ);

endmodule

// File: tb/tb_cursor_nav.sv
// Scoreboard bench for cursor_nav: three configurations (8x8 wrap, 5x6 wrap, 5x6 clamp)
// share one stimulus stream; a grid-arithmetic model predicts every cycle's outputs.
module tb_cursor_nav;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, up_v, down_v, left_v, right_v, center_v, en, ack;

  logic [2:0] cx [3];
  logic [2:0] cy [3];
  logic [2:0] rx [3];
  logic [2:0] ry [3];
  logic       mv [3];
  logic       rq [3];
  logic       bz [3];

  cursor_nav #(.GRID_W(8), .GRID_H(8), .X_BITS(3), .Y_BITS(3), .WRAP(1)) dut0 (
    .clk(clk), .rst(rst), .up_valid(up_v), .down_valid(down_v), .left_valid(left_v),
    .right_valid(right_v), .center_valid(center_v), .enable(en), .reveal_ack(ack),
    .cur_x(cx[0]), .cur_y(cy[0]), .moved(mv[0]), .reveal_req(rq[0]),
    .reveal_x(rx[0]), .reveal_y(ry[0]), .busy(bz[0]));

  cursor_nav #(.GRID_W(5), .GRID_H(6), .X_BITS(3), .Y_BITS(3), .WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .up_valid(up_v), .down_valid(down_v), .left_valid(left_v),
    .right_valid(right_v), .center_valid(center_v), .enable(en), .reveal_ack(ack),
    .cur_x(cx[1]), .cur_y(cy[1]), .moved(mv[1]), .reveal_req(rq[1]),
    .reveal_x(rx[1]), .reveal_y(ry[1]), .busy(bz[1]));

  cursor_nav #(.GRID_W(5), .GRID_H(6), .X_BITS(3), .Y_BITS(3), .WRAP(0)) dut2 (
    .clk(clk), .rst(rst), .up_valid(up_v), .down_valid(down_v), .left_valid(left_v),
    .right_valid(right_v), .center_valid(center_v), .enable(en), .reveal_ack(ack),
    .cur_x(cx[2]), .cur_y(cy[2]), .moved(mv[2]), .reveal_req(rq[2]),
    .reveal_x(rx[2]), .reveal_y(ry[2]), .busy(bz[2]));

  typedef struct packed {
    logic [2:0] x, y, rx, ry;
    logic       moved, req;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  exp3_t sb [$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: plain integer grid positions per configuration
  int gw [3] = '{8, 5, 5};
  int gh [3] = '{8, 6, 6};
  int wr [3] = '{1, 1, 0};
  int mx [3], my [3], mrx [3], mry [3], mreq [3];

  function automatic int move_axis(input int p, input int d, input int n, input int w);
    int q;
    q = p + d;
    if (w != 0) return (q + n) % n;
    if (q < 0) return 0;
    if (q > n - 1) return n - 1;
    return q;
  endfunction

  task automatic step(input bit u, d, l, r, c, e, a, rs);
    exp3_t ex;
    @(negedge clk);
    up_v = u; down_v = d; left_v = l; right_v = r; center_v = c; en = e; ack = a; rst = rs;
    for (int k = 0; k < 3; k++) begin
      int nx, ny;
      bit mvd;
      mvd = 1'b0;
      if (rs) begin
        mx[k] = 0; my[k] = 0; mrx[k] = 0; mry[k] = 0; mreq[k] = 0;
      end else if (mreq[k] != 0) begin
        if (a) mreq[k] = 0;
      end else if (e && c) begin
        mrx[k] = mx[k]; mry[k] = my[k]; mreq[k] = 1;
      end else if (e) begin
        nx = move_axis(mx[k], int'(r) - int'(l), gw[k], wr[k]);
        ny = move_axis(my[k], int'(d) - int'(u), gh[k], wr[k]);
        mvd = (nx != mx[k]) || (ny != my[k]);
        mx[k] = nx; my[k] = ny;
      end
      ex[k].x = 3'(mx[k]);   ex[k].y = 3'(my[k]);
      ex[k].rx = 3'(mrx[k]); ex[k].ry = 3'(mry[k]);
      ex[k].moved = mvd;     ex[k].req = (mreq[k] != 0);
    end
    sb.push_back(ex);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: outputs are valid every cycle, compared just after the edge
  initial begin
    exp3_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (cx[k] !== e[k].x || cy[k] !== e[k].y || mv[k] !== e[k].moved ||
              rq[k] !== e[k].req || bz[k] !== e[k].req ||
              (e[k].req && (rx[k] !== e[k].rx || ry[k] !== e[k].ry))) begin
            miscompares++;
            $display("FAIL cfg%0d @%0t: got x=%0d y=%0d mv=%0b req=%0b busy=%0b rx=%0d ry=%0d, want x=%0d y=%0d mv=%0b req=%0b rx=%0d ry=%0d",
                     k, $time, cx[k], cy[k], mv[k], rq[k], bz[k], rx[k], ry[k],
                     e[k].x, e[k].y, e[k].moved, e[k].req, e[k].rx, e[k].ry);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; up_v = 0; down_v = 0; left_v = 0; right_v = 0; center_v = 0; en = 0; ack = 0;
    for (int k = 0; k < 3; k++) begin
      mx[k] = 0; my[k] = 0; mrx[k] = 0; mry[k] = 0; mreq[k] = 0;
    end

    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    // three separate right pulses
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1, 0, 1, 0, 0); idle(1); end
    // walk to right edge and across it, then left back and up over row 0
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    // full down walk of 8 rows; clamp config sits on its corner
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0, 0);
    // opposing pulses cancel per axis
    step(1, 1, 0, 1, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 0);
    // reveal with movement in the same cycle, then pulses held off for 10 cycles
    step(0, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, i % 3 == 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    // reset during a request, then a stray ack
    step(0, 0, 1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0, 0);
    // disabled: every pulse ignored
    step(1, 1, 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // request started, then enable drops; ack still completes it
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(99) < 30, $urandom_range(99) < 30, $urandom_range(99) < 30,
           $urandom_range(99) < 30, $urandom_range(99) < 8, $urandom_range(99) < 90,
           $urandom_range(99) < 40, $urandom_range(199) == 0);
    end
    idle(1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
